// File: rtl/mem_initiator.sv
// mem_initiator: requester side of the single-outstanding req/gnt memory protocol.
// Takes one load/store from a valid/ready command port and holds the request
// until grant. Returns read data on a valid/ready response port and records the
// number of request cycles of each transaction.
// Optional request timeout: define MEM_INIT_TIMEOUT_EN.
module mem_initiator #(
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned LatCntWidth   = 16,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic                   cmd_we_i,
   input  logic [AddrWidth-1:0]   cmd_addr_i,
   input  logic [DataWidth-1:0]   cmd_wdata_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [DataWidth-1:0]   rsp_rdata_o,
   output logic                   rsp_err_o,
   output logic                   mem_req_o,
   input  logic                   mem_gnt_i,
   output logic                   mem_rw_o,
   output logic [AddrWidth-1:0]   mem_addr_o,
   output logic [DataWidth-1:0]   mem_wdata_o,
   input  logic [DataWidth-1:0]   mem_rdata_i,
   output logic [LatCntWidth-1:0] last_lat_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RSP  = 2'd2;
`ifdef MEM_INIT_TIMEOUT_EN
   localparam logic [1:0] S_ERR  = 2'd3;
`endif

   logic [1:0]             r_state;
   logic [1:0]             w_state_nxt;
   logic [LatCntWidth-1:0] r_cnt;
   logic [LatCntWidth-1:0] w_cnt_inc;
   logic                   w_accept;
   logic                   w_hs;

   assign cmd_ready_o = (r_state == S_IDLE);
   assign w_accept    = cmd_valid_i & cmd_ready_o;
   assign w_hs        = (r_state == S_REQ) & mem_req_o & mem_gnt_i;
   assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + LatCntWidth'(1);

`ifdef MEM_INIT_TIMEOUT_EN
   logic w_timeout;
   logic r_rsp_err;

   // Timeout fires on the edge that would end the TimeoutCycles-th request cycle
   assign w_timeout = (r_state == S_REQ) & ~mem_gnt_i &
                      (r_cnt == LatCntWidth'(TimeoutCycles - 1));
   assign rsp_err_o = r_rsp_err;

   // Error flag: set on timeout, cleared by a granted completion
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rsp_err <= 1'b0;
      end else if (w_hs) begin
         r_rsp_err <= 1'b0;
      end else if (w_timeout) begin
         r_rsp_err <= 1'b1;
      end
   end
`else
   logic w_unused_timeout;

   assign w_unused_timeout = TimeoutCycles[0];
   assign rsp_err_o        = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a grant coinciding with timeout completes normally
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_REQ;
         S_REQ: begin
            if (w_hs) begin
               w_state_nxt = S_RSP;
            end
`ifdef MEM_INIT_TIMEOUT_EN
            else if (w_timeout) begin
               w_state_nxt = S_ERR;
            end
`endif
         end
         S_RSP:  if (rsp_ready_i) w_state_nxt = S_IDLE;
`ifdef MEM_INIT_TIMEOUT_EN
         S_ERR:  w_state_nxt = S_ERR;
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Memory request, response and latency registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_req_o   <= 1'b0;
         mem_rw_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         last_lat_o  <= '0;
         r_cnt       <= '0;
      end else begin
         if (w_accept) begin
            mem_req_o   <= 1'b1;
            mem_rw_o    <= cmd_we_i;
            mem_addr_o  <= cmd_addr_i;
            mem_wdata_o <= cmd_wdata_i;
            r_cnt       <= '0;
         end
         if (r_state == S_REQ) begin
            if (w_hs) begin
               mem_req_o   <= 1'b0;
               rsp_valid_o <= 1'b1;
               rsp_rdata_o <= mem_rw_o ? '0 : mem_rdata_i;
               last_lat_o  <= w_cnt_inc;
            end
`ifdef MEM_INIT_TIMEOUT_EN
            else if (w_timeout) begin
               mem_req_o   <= 1'b0;
               rsp_valid_o <= 1'b1;
               rsp_rdata_o <= '0;
               last_lat_o  <= LatCntWidth'(TimeoutCycles);
            end
`endif
            else begin
               r_cnt <= w_cnt_inc;
            end
         end
         if (rsp_valid_o && rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Requester (initiator) side of the single-outstanding req/gnt memory protocol used by the team's slow memory responder.
- Accepts one load/store command at a time from a CPU-side valid/ready port and drives mem_req/mem_rw/mem_addr/mem_wdata, holding them until grant.
- Captures read data at the handshake and returns it on a valid/ready response port.
- Measures per-transaction latency for performance counters.

Parameters:
AddrWidth, 32, memory address width
DataWidth, 32, memory data width
LatCntWidth, 16, width of latency counter / last_lat_o
TimeoutCycles, 1024, cycles req may stay unanswered before error (used only with MEM_INIT_TIMEOUT_EN)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_addr_i  in  AddrWidth  byte address
cmd_wdata_i  in  DataWidth  write data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rdata_o  out  DataWidth  read data (0 for writes)
rsp_err_o  out  1  transaction aborted by timeout
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory grant
mem_rw_o  out  1  1=write
mem_addr_o  out  AddrWidth  memory address
mem_wdata_o  out  DataWidth  memory write data
mem_rdata_i  in  DataWidth  memory read data, valid while mem_gnt_i=1
last_lat_o  out  LatCntWidth  cycles mem_req_o was high in last completed transaction

Behaviour:
- Reset (async, rst_ni low): state S_IDLE. All outputs 0: mem_req_o, mem_rw_o, mem_addr_o, mem_wdata_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, last_lat_o. Internal counter is 0.
- All mem_* and rsp_* outputs are registered. cmd_ready_o = (state==S_IDLE), combinational from state only.
- S_IDLE: on cmd_valid_i & cmd_ready_o:
  - Register we/addr/wdata onto mem_rw_o/mem_addr_o/mem_wdata_o.
  - Set mem_req_o=1 and clear the latency counter.
  - Go S_REQ.
  - mem_req_o rises the cycle after acceptance.
- S_REQ:
  - mem_req_o, mem_rw_o, mem_addr_o, mem_wdata_o are held stable.
  - Counter increments each cycle, saturating at all-ones.
  - Handshake = mem_req_o & mem_gnt_i sampled at a clock edge. At that edge:
    - mem_req_o <= 0, so req is low the very next cycle; the responder must not see a second request.
    - rsp_rdata_o <= mem_rw_o ? 0 : mem_rdata_i.
    - rsp_valid_o <= 1; rsp_err_o <= 0.
    - last_lat_o <= counter+1 (saturating); this includes the handshake cycle.
    - Go S_RSP.
- mem_gnt_i high while not in S_REQ is ignored.
- S_RSP:
  - rsp_valid_o, rsp_rdata_o, rsp_err_o are held.
  - On rsp_ready_i: rsp_valid_o <= 0 and go S_IDLE. rsp_rdata_o/rsp_err_o keep their values until the next response.
  - A new command is not accepted in the same cycle; minimum spacing between transactions is one idle cycle.
- mem_addr_o/mem_wdata_o/mem_rw_o retain their last values when idle.
- Reset mid-transaction drops mem_req_o immediately (async). The memory side must be reset together with this block.
- A write completes at the handshake edge; its response carries rsp_rdata_o=0.

Optional Feature:
- Macro MEM_INIT_TIMEOUT_EN.
- Defined:
  - In S_REQ, if the counter reaches TimeoutCycles with no grant: mem_req_o <= 0, rsp_valid_o <= 1, rsp_err_o <= 1, rsp_rdata_o <= 0, last_lat_o <= TimeoutCycles, then go S_ERR.
  - S_ERR presents the response like S_RSP. After rsp_ready_i it stays in S_ERR with cmd_ready_o=0 until reset, because the responder state is unknown.
  - A grant in the same cycle as timeout wins (normal completion).
- Undefined: no timeout, S_ERR absent, rsp_err_o tied 0, and S_REQ waits forever.

Test Plan:
- Reset: assert rst_ni=0 mid-S_REQ -> mem_req_o=0, rsp_valid_o=0, cmd_ready_o=1 asynchronously; last_lat_o=0.
- Read: cmd addr=0x10, we=0; bench responder returns gnt with rdata=0xDEADBEEF in the 6th req cycle -> mem_req_o high exactly 6 cycles, low the next cycle, rsp_rdata_o=0xDEADBEEF, rsp_err_o=0, last_lat_o=6.
- Write: cmd addr=0x20, wdata=0xCAFEF00D, we=1; gnt in 3rd req cycle -> mem_rw_o=1 and mem_wdata_o=0xCAFEF00D stable all 3 cycles, rsp_rdata_o=0, last_lat_o=3.
- Response backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o held, cmd_ready_o=0, mem_req_o=0 throughout; cmd_valid_i held high is accepted only after rsp_ready_i and return to S_IDLE.
- Back-to-back: 3 reads with gnt available immediately (1st req cycle) -> each last_lat_o=1, mem_req_o never high on two consecutive transactions without an intervening low cycle, data returned in order.
- With MEM_INIT_TIMEOUT_EN, TimeoutCycles=8, no gnt -> mem_req_o drops after 8 cycles, rsp_err_o=1, rsp_rdata_o=0, cmd_ready_o stays 0 after rsp_ready_i until reset.
